// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  // Request-side state of the fetch unit.
  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // One prefetched instruction: the PC handed to decode is fetch address + 4.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO holding {pc, instr} pairs between the
// memory port and the IF/ID register. Flush wins over push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  fetch_entry_t                 push_entry,
  output fetch_entry_t                 head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR   = PTR_W'(DEPTH - 1);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & ((count != FULL_COUNT) | do_pop);
  assign head    = empty ? '{pc: 32'h0, instr: NOP_WORD} : mem[rd_ptr];

  // Pointer and occupancy bookkeeping; a flush empties the FIFO in one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Entry storage needs no reset because head is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: owns the fetch PC, runs the req/ack instruction memory
// port and feeds decode from a prefetch FIFO, honouring freeze and redirects.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        valid,
  output logic [31:0] Instruction,
  output logic [31:0] PC
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  fetch_state_t     state;
  fetch_state_t     state_next;
  logic [31:0]      fetch_pc;
  logic [31:0]      drain_addr;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] count_after;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  fetch_entry_t     head;

  assign pop         = ~fifo_empty & ~freeze & ~branch_taken;
  assign push        = (state == REQ) & imem_ack & ~branch_taken;
  assign count_after = fifo_count + {{(CNT_W-1){1'b0}}, push}
                                  - {{(CNT_W-1){1'b0}}, pop};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .push       (push),
    .pop        (pop),
    .flush      (branch_taken),
    .push_entry ('{pc: next_pc(fetch_pc), instr: imem_rdata}),
    .head       (head),
    .count      (fifo_count),
    .empty      (fifo_empty)
  );

  assign valid       = ~fifo_empty;
  assign Instruction = head.instr;
  assign PC          = head.pc;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Next state: keep requesting while there is room; a redirect that catches
  // an unacknowledged request has to drain it before the new target can go out.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (branch_taken || fifo_count < DEPTH_CNT) state_next = REQ;
      end
      REQ: begin
        if (branch_taken)  state_next = imem_ack ? REQ : DRAIN;
        else if (imem_ack) state_next = (count_after < DEPTH_CNT) ? REQ : IDLE;
      end
      DRAIN: begin
        if (imem_ack) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  // Memory port outputs; during a drain the abandoned address stays on the bus.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = fetch_pc;
    unique case (state)
      REQ:   imem_req = 1'b1;
      DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = drain_addr;
      end
      default: imem_req = 1'b0;
    endcase
  end

  // Fetch PC advances on each accepted word and jumps on a redirect; the
  // outstanding address is captured when a redirect forces a drain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc   <= RESET_PC;
      drain_addr <= RESET_PC;
    end else begin
      if (branch_taken) fetch_pc <= branch_address;
      else if (push)    fetch_pc <= next_pc(fetch_pc);
      if (state == REQ && branch_taken && !imem_ack) drain_addr <= fetch_pc;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: a program-order reference stream is
// compared against every instruction that decode consumes, plus directed
// timing checks around reset, freeze and redirects.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] SCRAMBLE = 32'hE000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        freeze = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_address = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        valid;
  logic [31:0] Instruction;
  logic [31:0] PC;

  int checks = 0;
  int errors = 0;
  int consumed = 0;
  int lat_min = 0;
  int lat_max = 0;
  int cur_lat = 0;
  int waited = 0;

  logic [31:0] exp_q[$];
  logic [31:0] next_addr;

  instruction_fetch_unit #(
    .RESET_PC   (RESET_PC),
    .FIFO_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .freeze         (freeze),
    .branch_taken   (branch_taken),
    .branch_address (branch_address),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .valid          (valid),
    .Instruction    (Instruction),
    .PC             (PC)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: after reset or a redirect decode must see consecutive
  // words starting at the new address, each word being its address scrambled.
  function automatic void restart_stream(input logic [31:0] start);
    exp_q.delete();
    next_addr = start;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(next_addr);
      next_addr = next_addr + 32'd4;
    end
  endfunction

  function automatic void set_latency(input int lo, input int hi);
    lat_min = lo;
    lat_max = hi;
    cur_lat = hi;
  endfunction

  task automatic apply_stimulus(input logic f, input logic b, input logic [31:0] addr);
    @(posedge clk);
    #1;
    freeze = f;
    branch_taken = b;
    branch_address = addr;
    if (b) restart_stream(addr);
  endtask

  task automatic pulse_reset(input int cycles);
    @(posedge clk);
    #1;
    rst = 1'b0;
    branch_taken = 1'b0;
    restart_stream(RESET_PC);
    #1;
    check_output("reset_async_req", 64'({imem_req, imem_addr}), 64'({1'b0, RESET_PC}));
    check_output("reset_async_out", 64'({valid, PC, Instruction}), 64'(0));
    repeat (cycles) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic wait_for_req(input logic [31:0] addr, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!(imem_req === 1'b1 && imem_addr === addr) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_output(name, 64'({imem_req, imem_addr}), 64'({1'b1, addr}));
  endtask

  // Memory model: acknowledges a request after cur_lat waiting cycles and
  // returns the scrambled address.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        imem_ack = 1'b0;
        waited = 0;
      end else if (imem_req && waited >= cur_lat) begin
        imem_ack = 1'b1;
        imem_rdata = imem_addr ^ SCRAMBLE;
        waited = 0;
        cur_lat = $urandom_range(lat_max, lat_min);
      end else begin
        imem_ack = 1'b0;
        imem_rdata = 32'hBAD0_BAD0;
        if (imem_req) waited++;
      end
    end
  end

  // Monitor: pops the reference stream on every consumed instruction and
  // checks freeze stability, empty outputs and request address stability.
  initial begin
    logic        hold_prev;
    logic [64:0] prev_out;
    logic        pend_prev;
    logic [31:0] pend_addr;
    logic [31:0] a;
    hold_prev = 1'b0;
    pend_prev = 1'b0;
    prev_out = '0;
    pend_addr = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (hold_prev)
          check_output("freeze_stable", 64'({PC, Instruction}), prev_out[63:0]);
        if (hold_prev)
          check_output("freeze_valid", 64'(valid), 64'(prev_out[64]));
        if (pend_prev && imem_req)
          check_output("addr_stable", 64'(imem_addr), 64'(pend_addr));
        if (!valid)
          check_output("empty_zero", 64'({PC, Instruction}), 64'(0));
        if (valid && !freeze && !branch_taken) begin
          if (exp_q.size() == 0) begin
            check_output("stream_underflow", 64'(PC), 64'(0));
          end else begin
            a = exp_q.pop_front();
            exp_q.push_back(next_addr);
            next_addr = next_addr + 32'd4;
            consumed++;
            check_output("stream", {PC, Instruction}, {a + 32'd4, a ^ SCRAMBLE});
          end
        end
        hold_prev = valid && freeze && !branch_taken;
        prev_out = {valid, PC, Instruction};
        pend_prev = imem_req && !imem_ack;
        pend_addr = imem_addr;
      end else begin
        hold_prev = 1'b0;
        pend_prev = 1'b0;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        f;
    logic        b;
    logic [31:0] a;
    set_latency(0, 0);
    restart_stream(RESET_PC);

    // Reset values, then first fetch timing with zero-wait memory.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("reset_req", 64'({imem_req, imem_addr}), 64'({1'b0, RESET_PC}));
    check_output("reset_out", 64'({valid, PC, Instruction}), 64'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check_output("idle_after_release", 64'(imem_req), 64'(0));
    @(negedge clk);
    check_output("first_req", 64'({imem_req, imem_addr, valid}), 64'({1'b1, RESET_PC, 1'b0}));
    @(negedge clk);
    check_output("first_valid", 64'({valid, PC}), 64'({1'b1, RESET_PC + 32'd4}));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_output("no_gap", 64'(valid), 64'(1));
    end

    // Freeze for four cycles with one-cycle memory latency.
    set_latency(1, 1);
    repeat (6) @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    check_output("freeze_full_idle", 64'({imem_req, valid}), 64'({1'b0, 1'b1}));
    apply_stimulus(1'b0, 1'b0, 32'h0);
    repeat (6) @(negedge clk);

    // Redirect to 0x100 with nothing outstanding.
    set_latency(0, 0);
    repeat (4) @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 32'h0);
    @(negedge clk);
    check_output("full_no_req", 64'(imem_req), 64'(0));
    apply_stimulus(1'b0, 1'b1, 32'h100);
    @(negedge clk);
    apply_stimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("branch_gap", 64'({valid, imem_req, imem_addr}), 64'({1'b0, 1'b1, 32'h100}));
    apply_stimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("branch_word", {PC, Instruction}, {32'h104, 32'h100 ^ SCRAMBLE});
    repeat (3) @(negedge clk);

    // Redirect while the request to 0x08 waits three cycles for its ack.
    freeze = 1'b1;
    pulse_reset(2);
    repeat (5) @(negedge clk);
    check_output("prefill_idle", 64'(imem_req), 64'(0));
    set_latency(3, 3);
    apply_stimulus(1'b0, 1'b0, 32'h0);
    wait_for_req(32'h8, "req_to_08");
    apply_stimulus(1'b0, 1'b1, 32'h100);
    @(negedge clk);
    check_output("drain_c2", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h8}));
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1'b0, 1'b0, 32'h0);
      @(negedge clk);
      check_output("drain_hold", 64'({valid, imem_req, imem_addr}), 64'({1'b0, 1'b1, 32'h8}));
    end
    apply_stimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("after_drain", 64'({valid, imem_req, imem_addr}), 64'({1'b0, 1'b1, 32'h100}));
    set_latency(0, 0);
    repeat (8) @(negedge clk);

    // Redirect in the same cycle as an acknowledge.
    apply_stimulus(1'b0, 1'b1, 32'h200);
    @(negedge clk);
    check_output("ack_with_branch", 64'({imem_req, imem_ack}), 64'(2'b11));
    apply_stimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("ack_branch_next", 64'({valid, imem_req, imem_addr}), 64'({1'b0, 1'b1, 32'h200}));
    apply_stimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_output("ack_branch_word", {PC, Instruction}, {32'h204, 32'h200 ^ SCRAMBLE});

    // Reset pulse while a request is outstanding.
    set_latency(3, 3);
    repeat (4) @(negedge clk);
    @(negedge clk);
    while (!(imem_req && !imem_ack) && consumed < 100000) @(negedge clk);
    pulse_reset(2);
    set_latency(0, 0);
    @(negedge clk);
    check_output("restart_idle", 64'(imem_req), 64'(0));
    @(negedge clk);
    check_output("restart_addr", 64'({imem_req, imem_addr}), 64'({1'b1, RESET_PC}));
    repeat (4) @(negedge clk);

    // Randomized freezes, redirects (including near the top of memory) and latency.
    set_latency(0, 3);
    for (int i = 0; i < 500; i++) begin
      f = ($urandom_range(99, 0) < 30);
      b = ($urandom_range(99, 0) < 5);
      a = ($urandom_range(3, 0) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      apply_stimulus(f, b, a);
    end
    for (int i = 0; i < 12; i++) apply_stimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);

    check_output("stream_progress", 64'(consumed > 100), 64'(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
